nibble_serial_subtractor: RTL and testbench

- Multi-cycle subtractor that computes D = A - B - Bin over WIDTH-bit operands, resolving one 4-bit digit per clock.
- Each digit uses a 4-bit generate/propagate lookahead on A + ~B + carry; the borrow is carried between digits in a register.
- Sits beside the combinational 4-bit lookahead adder as its inverse operation, for datapaths that trade latency for area.
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/nibble_serial_subtractor.sv | 144 ++++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: computes D = A - B - Bin over WIDTH bits, resolving
// one 4-bit digit per clock with a 4-bit generate/propagate lookahead on
// A + ~B + carry. The carry between digits is held in a register.
// Optional feature macro: NIBBLE_SUB_OVF_EN adds the signed overflow output ovf.
module nibble_serial_subtractor #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
`ifdef NIBBLE_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             Bout
);

   localparam int NIB   = WIDTH / 4;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             c_q, c_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             bout_q, bout_d;

   logic [3:0] a_nib, nb_nib, g, p, sum;
   logic       c1, c2, c3, c4;

   // Digit lookahead: the operand registers shift right so the active digit
   // is always in bits [3:0]; borrow is formed as the inverted carry of A + ~B.
   always_comb begin
      a_nib  = a_q[3:0];
      nb_nib = ~b_q[3:0];
      g      = a_nib & nb_nib;
      p      = a_nib ^ nb_nib;
      c1     = g[0] | (p[0] & c_q);
      c2     = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
      c3     = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_q);
      c4     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_q);
      sum    = p ^ {c3, c2, c1, c_q};
   end

   // Next-state, counter, operand and result update logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      bout_d  = bout_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = A;
               b_d     = B;
               c_d     = ~Bin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < NIB; k++) begin
               if (cnt_q == CNT_W'(k)) d_d[4*k +: 4] = sum;
            end
            a_d = a_q >> 4;
            b_d = b_q >> 4;
            c_d = c4;
            if (cnt_q == CNT_W'(NIB - 1)) begin
               cnt_d   = '0;
               bout_d  = ~c4;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and result registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         d_q     <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
      end
   end

   // Operand shift registers carry no reset; they are loaded on acceptance.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

`ifdef NIBBLE_SUB_OVF_EN
   logic ovf_q, ovf_d;

   // Signed overflow: carry into the MSB differs from carry out of the final digit.
   always_comb begin
      ovf_d = ovf_q;
      if (state_q == RUN && cnt_q == CNT_W'(NIB - 1)) ovf_d = c3 ^ c4;
   end

   // Overflow flag register, captured alongside Bout.
   always_ff @(posedge clk) begin
      if (!rst_n) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign D         = d_q;
   assign Bout      = bout_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor (WIDTH=16).
// Build with NIBBLE_SUB_OVF_EN defined to also check the ovf output.
module tb_nibble_serial_subtractor;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic        Bin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] D;
   logic        Bout;
`ifdef NIBBLE_SUB_OVF_EN
   logic        ovf;
`endif

   int checks = 0;
   int errors = 0;

   nibble_serial_subtractor #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Bin       (Bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .D         (D),
`ifdef NIBBLE_SUB_OVF_EN
      .ovf       (ovf),
`endif
      .Bout      (Bout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full operation with out_ready held high; entered and left at #1 after an edge.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [15:0] ed, input logic eb, input logic eo);
      chk("idle_ready", 16'(in_ready), 16'd1);
      A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("run_busy", 16'(in_ready), 16'd0);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk(k < 4 ? "early_valid" : "valid_at_4", 16'(out_valid), (k < 4) ? 16'd0 : 16'd1);
      end
      chk("diff", D, ed);
      chk("bout", 16'(Bout), 16'(eb));
`ifdef NIBBLE_SUB_OVF_EN
      chk("ovf", 16'(ovf), 16'(eo));
`else
      if (eo === 1'bx) $display("note: ovf expectation unknown");
`endif
      step();
      chk("post_hs_valid", 16'(out_valid), 16'd0);
      chk("post_hs_ready", 16'(in_ready), 16'd1);
      chk("d_retained", D, ed);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Bin = 1'b0; out_ready = 1'b1;
      step();
      step();
      chk("rst_ready", 16'(in_ready), 16'd1);
      chk("rst_valid", 16'(out_valid), 16'd0);
      chk("rst_d", D, 16'h0000);
      chk("rst_bout", 16'(Bout), 16'd0);
`ifdef NIBBLE_SUB_OVF_EN
      chk("rst_ovf", 16'(ovf), 16'd0);
`endif
      rst_n = 1'b1;
      step();

      do_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
      do_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      do_op(16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0);
      do_op(16'h00FF, 16'h00FF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      do_op(16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0);
      do_op(16'h1234, 16'hABCD, 1'b0, 16'h6667, 1'b1, 1'b0);
      do_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
      do_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

      // Backpressure with in_valid pulsed while busy
      out_ready = 1'b0;
      A = 16'h4321; B = 16'h1111; Bin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      A = 16'hFFFF; B = 16'h0000; Bin = 1'b1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("bp_valid", 16'(out_valid), 16'd1);
      in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         chk("bp_d", D, 16'h3210);
         chk("bp_bout", 16'(Bout), 16'd0);
         chk("bp_ready", 16'(in_ready), 16'd0);
         chk("bp_hold", 16'(out_valid), 16'd1);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk("bp_release_valid", 16'(out_valid), 16'd0);
      chk("bp_release_ready", 16'(in_ready), 16'd1);
      step();
      chk("bp_no_accept", 16'(in_ready), 16'd1);
      chk("bp_d_kept", D, 16'h3210);

      // Reset during the second RUN cycle
      A = 16'hFFFF; B = 16'h0001; Bin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_rst_ready", 16'(in_ready), 16'd1);
      chk("mid_rst_valid", 16'(out_valid), 16'd0);
      chk("mid_rst_d", D, 16'h0000);
      chk("mid_rst_bout", 16'(Bout), 16'd0);
      for (int k = 0; k < 6; k++) begin
         chk("mid_rst_no_result", 16'(out_valid), 16'd0);
         step();
      end
      do_op(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
